ifetch_unit: RTL

Instruction fetch stage for the RV32 core. It owns the fetch program counter and drives the word address into the combinational instruction memory, capturing the returned word in the same cycle. Fetched {pc, instr} pairs are buffered in a small prefetch FIFO and handed to decode over a valid/ready handshake. Branch and jump redirects from execute flush the buffer and restart fetch at the new target.

---
 rtl/rv32_pkg.sv | 19 +
 rtl/ifetch_unit_if.sv | 37 +++
 rtl/fetch_fifo.sv | 89 ++++++++
 rtl/ifetch_unit.sv | 69 ++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch stage: widths, reset vector,
// the buffered fetch entry type and an address alignment helper.
package rv32_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input from execute
// and the valid/ready handshake towards decode.
interface ifetch_unit_if;
  import rv32_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries. Flush wins over push and pop;
// a push into a full FIFO is accepted only when a pop frees the head slot.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] wr_en;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && !flush && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Storage is cleared on reset so the head outputs are never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= push_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/ifetch_unit.sv
// RV32 instruction fetch: PC register driving a combinational instruction
// memory, feeding a prefetch FIFO towards decode; redirects flush and restart.
module ifetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  ifetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_reg;
  logic [XLEN-1:0]  fetch_pc_next;
  logic             push;
  logic             pop;
  fetch_entry_t     push_data;
  fetch_entry_t     head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  assign pop  = bus.out_ready && !empty;
  // Redirect suppresses the push so the stale word at the old PC is dropped.
  assign push = !bus.redirect_valid && (!full || pop);

  assign push_data = '{pc: fetch_pc_reg, instr: bus.imem_instr};

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (bus.redirect_valid) begin
      fetch_pc_next = word_align(bus.redirect_pc);
    end else if (push) begin
      fetch_pc_next = fetch_pc_reg + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg <= word_align(RESET_PC);
    end else begin
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.imem_addr = word_align(fetch_pc_reg);
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;

endmodule
